// File: rtl/fpa_accumulator.sv
// rtl/fpa_accumulator.sv - run-length float accumulator sequencing a combinational fpu adder
module fpa_accumulator #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COUNT_W-1:0] len,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   output logic [31:0]        fpu_a,
   output logic [31:0]        fpu_b,
   input  logic [31:0]        fpu_sum,
   input  logic               fpu_ovf,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_sum,
   output logic               out_ovf,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t             state, state_nxt;
   logic [31:0]        acc;
   logic [COUNT_W-1:0] cnt, len_q, cnt_inc;
   logic               ovf_q;
   logic               accept;

   assign cnt_inc = cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
   assign accept  = (state == ACCUM) && in_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
         end else if (accept) begin
            // after an overflow the sum is pinned at zero; samples keep draining
            acc   <= ovf_q ? 32'h0 : fpu_sum;
            ovf_q <= ovf_q | fpu_ovf;
            cnt   <= cnt_inc;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      fpu_b     = 32'h0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = (len == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            fpu_b    = in_data;
            if (in_valid && cnt_inc == len_q)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fpu_a   = acc;
   assign out_sum = (state == DONE) ? acc : 32'h0;
   assign out_ovf = (state == DONE) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_fpa_accumulator.sv
// tb/tb_fpa_accumulator.sv - directed scoreboard bench for fpa_accumulator with a behavioural fpu
module tb_fpa_accumulator;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
   logic [7:0]  len;
   logic [31:0] in_data, fpu_a, fpu_b, fpu_sum, out_sum;
   logic        fpu_ovf;

   int checks = 0;
   int errors = 0;
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   fpa_accumulator #(.COUNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sum(fpu_sum), .fpu_ovf(fpu_ovf),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_ovf(out_ovf), .busy(busy)
   );

   // sign / unbiased exponent / explicit-1 mantissa adder; returns {ovf, sum}
   function automatic logic [32:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      int ex, ey, e;
      longint mx, my, m;
      logic s;
      if (a[22:0] == 23'd0) return {1'b0, b};
      if (b[22:0] == 23'd0) return {1'b0, a};
      x = a; y = b;
      if (b[30:23] > a[30:23]) begin x = b; y = a; end
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = longint'(x[22:0]);
      my = (ex - ey > 31) ? 64'd0 : longint'(y[22:0] >> (ex - ey));
      if (x[31] == y[31]) begin m = mx + my; s = x[31]; end
      else if (mx >= my) begin m = mx - my; s = x[31]; end
      else begin m = my - mx; s = y[31]; end
      if (m == 0) return 33'd0;
      e = ex;
      if (m >= 64'h800000) begin m = m >> 1; e++; end
      for (int i = 0; i < 23; i++)
         if (m < 64'h400000) begin m = m << 1; e--; end
      if (e > 255) return {1'b1, 32'd0};
      if (e < 0) return 33'd0;
      return {1'b0, s, e[7:0], m[22:0]};
   endfunction

   always_comb {fpu_ovf, fpu_sum} = fpu_model(fpu_a, fpu_b);

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input int gap, input logic poke_start);
      repeat (gap) begin
         in_valid = 1'b0;
         start    = poke_start;
         tick();
         chk("gap_busy", busy, 1);
         chk("gap_in_ready", in_ready, 1);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      chk("fpu_b_drive", fpu_b, d);
      chk("in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic collect(input int hold, input logic poke_start);
      int n;
      logic [32:0] exp;
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
      chk("out_valid_wait", out_valid, 1);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      exp = sb[0];
      repeat (hold) begin
         start = poke_start;
         chk("hold_sum", out_sum, exp[31:0]);
         chk("hold_ovf", out_ovf, exp[32]);
         chk("hold_busy", busy, 1);
         chk("hold_in_ready", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      exp = sb.pop_front();
      chk("out_sum", out_sum, exp[31:0]);
      chk("out_ovf", out_ovf, exp[32]);
      tick();
      out_ready = 1'b0;
      chk("post_out_valid", out_valid, 0);
      chk("post_busy", busy, 0);
      start = 1'b0;
      tick();
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      logic [31:0] smp[5];
      logic [32:0] e, r;

      rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_ovf", out_ovf, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fpu_a", fpu_a, 0);
      chk("rst_fpu_b", fpu_b, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // 9.75 + 18.5625
      sb.push_back({1'b0, 32'h02714000});
      start_run(8'd2);
      chk("run1_busy", busy, 1);
      send(32'h01CE0000, 0, 1'b0);
      chk("run1_mid_out_valid", out_valid, 0);
      send(32'h024A4000, 0, 1'b0);
      chk("run1_latency", out_valid, 1);
      collect(0, 1'b0);

      // 9.125 + -7.625
      sb.push_back({1'b0, 32'h00600000});
      start_run(8'd2);
      send(32'h01C90000, 0, 1'b0);
      send(32'h817A0000, 0, 1'b0);
      collect(0, 1'b0);

      // sticky overflow, remaining sample still consumed
      sb.push_back({1'b1, 32'h00000000});
      start_run(8'd3);
      send(32'h7FFFFFFF, 0, 1'b0);
      send(32'h7FFFFFFF, 0, 1'b0);
      chk("ovf_still_ready", in_ready, 1);
      send(32'h00600000, 0, 1'b0);
      chk("ovf_latency", out_valid, 1);
      collect(0, 1'b0);

      // empty run
      sb.push_back({1'b0, 32'h00000000});
      start_run(8'd0);
      chk("empty_out_valid", out_valid, 1);
      chk("empty_in_ready", in_ready, 0);
      collect(1, 1'b0);

      // back-pressure with gapped input and ignored start pulses
      sb.push_back({1'b0, 32'h02714000});
      start_run(8'd2);
      send(32'h01CE0000, 3, 1'b1);
      send(32'h024A4000, 3, 1'b1);
      collect(5, 1'b1);

      // reset mid-run
      start_run(8'd3);
      send(32'h01CE0000, 0, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_fpu_a", fpu_a, 0);
      rst = 1'b0;
      tick();
      sb.push_back({1'b0, 32'h00600000});
      start_run(8'd1);
      send(32'h00600000, 0, 1'b0);
      collect(0, 1'b0);

      // longer run of random small positives, expected chained through the fpu model
      e = 33'd0;
      for (int i = 0; i < 5; i++) begin
         smp[i] = {1'b0, 8'($urandom_range(0, 10)), 1'b1, 22'($urandom)};
         r = fpu_model(e[31:0], smp[i]);
         e = {e[32] | r[32], e[32] ? 32'h0 : r[31:0]};
      end
      sb.push_back(e);
      start_run(8'd5);
      for (int i = 0; i < 5; i++) send(smp[i], i % 2, 1'b0);
      collect(2, 1'b0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
